avalon_uart_fifo: RTL

AVALON_UART_FIFO -- requirements
Module: avalon_uart_fifo

---
 rtl/avalon_uart_fifo_pkg.sv | 28 ++
 rtl/avalon_uart_fifo_if.sv | 32 +++
 rtl/avalon_uart_fifo_fifo.sv | 62 ++++++
 rtl/avalon_uart_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_uart_fifo_pkg.sv
// Shared constants for the Avalon UART FIFO bridge.
// Holds the register map, the bit layout of the DATA and CONTROL words, and the read FSM states.
package avalon_uart_pkg;

    localparam logic ADDR_DATA    = 1'b0;
    localparam logic ADDR_CONTROL = 1'b1;

    localparam int CTRL_RE  = 0;
    localparam int CTRL_WE  = 1;
    localparam int CTRL_RI  = 8;
    localparam int CTRL_WI  = 9;
    localparam int CTRL_AC  = 10;
    localparam int CTRL_OVF = 11;

    localparam int DATA_RVALID = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } rd_state_e;

    // Occupancy fields in the upper half-word clamp instead of wrapping.
    function automatic logic [15:0] sat16(input logic [31:0] value);
        return (value > 32'h0000_FFFF) ? 16'hFFFF : value[15:0];
    endfunction

endpackage

// File: rtl/avalon_uart_fifo_if.sv
// Avalon-MM slave signal bundle for the UART FIFO bridge.
interface avalon_uart_fifo_if;

    logic        uart_chipselect;
    logic        uart_address;
    logic        uart_read_n;
    logic        uart_write_n;
    logic [31:0] uart_writedata;
    logic [31:0] uart_readdata;
    logic        uart_waitrequest;

    modport slave (
        input  uart_chipselect,
        input  uart_address,
        input  uart_read_n,
        input  uart_write_n,
        input  uart_writedata,
        output uart_readdata,
        output uart_waitrequest
    );

    modport master (
        output uart_chipselect,
        output uart_address,
        output uart_read_n,
        output uart_write_n,
        output uart_writedata,
        input  uart_readdata,
        input  uart_waitrequest
    );

endinterface

// File: rtl/avalon_uart_fifo_fifo.sv
// Synchronous FIFO with combinational head and occupancy count.
// A push is accepted while full only when a pop retires an entry in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avalon_uart_fifo.sv
// Avalon-MM slave bridging a byte-wide TX and RX stream through two FIFOs,
// with a two-wait-state read path, optional write stalling, and a level interrupt.
module avalon_uart_fifo
    import avalon_uart_pkg::*;
#(
    parameter int RX_DEPTH = 64,
    parameter int TX_DEPTH = 64,
    parameter int WR_BLOCK = 0
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    avalon_uart_fifo_if.slave   avs,
    output logic                irq_irq,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready
);

    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]       w_rxHead;
    logic             w_rxFull;
    logic             w_rxEmpty;
    logic [RX_CW-1:0] w_rxCount;
    logic [7:0]       w_txHead;
    logic             w_txFull;
    logic             w_txEmpty;
    logic [TX_CW-1:0] w_txCount;

    logic             w_rxPush;
    logic             w_rxPop;
    logic             w_txPush;
    logic             w_txPop;

    logic             w_read;
    logic             w_write;
    logic             w_dataWrite;
    logic             w_ctrlWrite;
    logic             w_txBlocked;
    logic             w_txStall;
    logic             w_txDrop;
    logic             w_waitreq;
    logic             w_ri;
    logic             w_wi;
    logic [31:0]      w_rxAfter;
    logic [31:0]      w_dataWord;
    logic [31:0]      w_ctrlWord;
    logic             w_unused;

    rd_state_e        r_state;
    rd_state_e        w_nextState;
    logic [31:0]      r_readdata;
    logic             r_popPending;
    logic             r_alive;
    logic             r_re;
    logic             r_we;
    logic             r_ac;
    logic             r_ovf;
    logic             r_irq;

    sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rxFifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_rxPush),
        .i_wdata (rx_data),
        .i_pop   (w_rxPop),
        .o_rdata (w_rxHead),
        .o_full  (w_rxFull),
        .o_empty (w_rxEmpty),
        .o_count (w_rxCount)
    );

    sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_txFifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_txPush),
        .i_wdata (avs.uart_writedata[7:0]),
        .i_pop   (w_txPop),
        .o_rdata (w_txHead),
        .o_full  (w_txFull),
        .o_empty (w_txEmpty),
        .o_count (w_txCount)
    );

    // r_alive holds rx_ready low through reset and releases it on the first clock afterwards.
    assign rx_ready = r_alive & ~w_rxFull;
    assign tx_valid = ~w_txEmpty;
    assign tx_data  = w_txHead;
    assign w_rxPush = rx_valid & rx_ready;
    assign w_txPop  = tx_valid & tx_ready;

    assign w_read      = avs.uart_chipselect & ~avs.uart_read_n;
    assign w_write     = avs.uart_chipselect & ~avs.uart_write_n & ~w_read;
    assign w_dataWrite = w_write & (r_state == IDLE) & (avs.uart_address == ADDR_DATA);
    assign w_ctrlWrite = w_write & (r_state == IDLE) & (avs.uart_address == ADDR_CONTROL);
    assign w_txBlocked = w_dataWrite & w_txFull & ~w_txPop;
    assign w_txStall   = w_txBlocked & (WR_BLOCK != 0);
    assign w_txDrop    = w_txBlocked & (WR_BLOCK == 0);
    assign w_txPush    = w_dataWrite & (~w_txFull | w_txPop);

    assign w_ri = (w_rxCount >= RX_CW'(RX_DEPTH / 2)) | w_rxFull;
    assign w_wi = (w_txCount <= TX_CW'(TX_DEPTH / 4));

    assign w_rxAfter = w_rxEmpty ? 32'd0 : (32'(w_rxCount) - 32'd1);

    always_comb begin
        w_dataWord              = '0;
        w_dataWord[7:0]         = w_rxEmpty ? 8'h00 : w_rxHead;
        w_dataWord[DATA_RVALID] = ~w_rxEmpty;
        w_dataWord[31:16]       = sat16(w_rxAfter);
    end

    always_comb begin
        w_ctrlWord           = '0;
        w_ctrlWord[CTRL_RE]  = r_re;
        w_ctrlWord[CTRL_WE]  = r_we;
        w_ctrlWord[CTRL_RI]  = w_ri;
        w_ctrlWord[CTRL_WI]  = w_wi;
        w_ctrlWord[CTRL_AC]  = r_ac;
        w_ctrlWord[CTRL_OVF] = r_ovf;
        w_ctrlWord[31:16]    = sat16(32'(TX_DEPTH) - 32'(w_txCount));
    end

    // Reads always take two wait states; a stalled TX write is the only other waitrequest source.
    always_comb begin
        w_nextState = r_state;
        w_waitreq   = 1'b0;
        w_rxPop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_read) begin
                    w_nextState = RD_WAIT;
                    w_waitreq   = 1'b1;
                end else begin
                    w_waitreq   = w_txStall;
                end
            end
            RD_WAIT: begin
                w_nextState = RD_DONE;
                w_waitreq   = w_read;
            end
            RD_DONE: begin
                w_nextState = IDLE;
                w_rxPop     = r_popPending;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign avs.uart_waitrequest = w_waitreq & ~reset_reset;
    assign avs.uart_readdata    = r_readdata;
    assign irq_irq              = r_irq;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state      <= IDLE;
            r_readdata   <= '0;
            r_popPending <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == RD_WAIT) begin
                r_readdata   <= (avs.uart_address == ADDR_DATA) ? w_dataWord : w_ctrlWord;
                r_popPending <= (avs.uart_address == ADDR_DATA) & ~w_rxEmpty;
            end
        end
    end

    // A stream transfer in the same cycle as a clear request wins, so no activity is lost.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_alive <= 1'b0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_ac    <= 1'b0;
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_ctrlWrite) begin
                r_re <= avs.uart_writedata[CTRL_RE];
                r_we <= avs.uart_writedata[CTRL_WE];
            end
            if (w_rxPush | w_txPop) begin
                r_ac <= 1'b1;
            end else if (w_ctrlWrite & avs.uart_writedata[CTRL_AC]) begin
                r_ac <= 1'b0;
            end
            if (w_txDrop) begin
                r_ovf <= 1'b1;
            end else if (w_ctrlWrite & avs.uart_writedata[CTRL_OVF]) begin
                r_ovf <= 1'b0;
            end
            r_irq <= (r_re & w_ri) | (r_we & w_wi);
        end
    end

    assign w_unused = &{1'b0, avs.uart_writedata[31:12], avs.uart_writedata[9:8]};

endmodule
